// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory access unit.
//   state_t          - access FSM state encoding
//   ERR_DATA_DEFAULT - load data returned when a read times out
//   TO_CNT_W         - width of the REQ+WAIT timeout counter
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;
  localparam int          TO_CNT_W         = 10;

endpackage

// File: rtl/wait_counter.sv
// wait_counter: clear/enable counter that flags the last allowed cycle of an
// access.
//   clock, reset - rising-edge clock, synchronous active-high reset
//   clear        - restart counting from zero
//   enable       - count this cycle (access is in REQ or WAIT)
//   tc           - high while enabled in the cycle whose increment makes the
//                  count reach TIMEOUT, i.e. the TIMEOUT-th busy cycle
module wait_counter
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [TO_CNT_W-1:0] count_r;

  // Busy-cycle counter; the FSM aborts before it could pass TIMEOUT.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_r <= {TO_CNT_W{1'b0}};
    end else if (enable) begin
      count_r <= count_r + {{(TO_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign tc = enable && (count_r == TO_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: load/store stage between the single-cycle datapath and a
// data memory with a req/gnt/rvalid handshake that may insert wait states.
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   memRead, memWrite   - access request from control (store wins if both)
//   addr, wData         - byte address and store data from the datapath
//   rData               - load data back to the datapath (held between loads)
//   stall               - hold PC / regfile while an access is in flight
//   misalign            - pulse: requested address not word aligned (dropped)
//   timeoutErr          - pulse in the DONE cycle of an aborted access
//   mReq, mWe, mAddr, mWData, mGnt, mRValid, mRData - memory handshake
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wData,
  output logic [DATA_W-1:0] rData,
  output logic              stall,
  output logic              misalign,
  output logic              timeoutErr,
  output logic              mReq,
  output logic              mWe,
  output logic [ADDR_W-1:0] mAddr,
  output logic [DATA_W-1:0] mWData,
  input  logic              mGnt,
  input  logic              mRValid,
  input  logic [DATA_W-1:0] mRData
);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              we_r;
  logic              timeout_err_r;

  logic valid_s;
  logic aligned_s;
  logic launch_s;
  logic complete_s;
  logic load_done_s;
  logic abort_s;
  logic busy_s;
  logic tc_s;

  assign valid_s   = memRead | memWrite;
  assign aligned_s = (addr[1:0] == 2'b00);
  assign busy_s    = (state_r == REQ) || (state_r == WAIT);

  wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (launch_s),
    .enable (busy_s),
    .tc     (tc_s)
  );

  // Next-state and handshake decode. A completion in the terminal cycle
  // takes precedence over the abort. A load granted in the terminal cycle
  // has not completed yet, so it is aborted.
  always_comb begin
    state_nxt_s = state_r;
    launch_s    = 1'b0;
    complete_s  = 1'b0;
    load_done_s = 1'b0;
    abort_s     = 1'b0;
    stall       = 1'b0;
    misalign    = 1'b0;
    mReq        = 1'b0;
    mWe         = 1'b0;
    case (state_r)
      IDLE: begin
        if (valid_s) begin
          if (aligned_s) begin
            launch_s    = 1'b1;
            stall       = 1'b1;
            state_nxt_s = REQ;
          end else begin
            misalign    = 1'b1;
          end
        end else begin
          stall = 1'b0;
        end
      end
      REQ: begin
        mReq  = 1'b1;
        mWe   = we_r;
        stall = 1'b1;
        if (mGnt) begin
          if (we_r) begin
            complete_s  = 1'b1;
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = WAIT;
          end
        end else begin
          state_nxt_s = REQ;
        end
        if (tc_s && !complete_s) begin
          abort_s     = 1'b1;
          state_nxt_s = DONE;
        end else begin
          abort_s = 1'b0;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (mRValid) begin
          complete_s  = 1'b1;
          load_done_s = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = WAIT;
        end
        if (tc_s && !complete_s) begin
          abort_s     = 1'b1;
          state_nxt_s = DONE;
        end else begin
          abort_s = 1'b0;
        end
      end
      DONE: begin
        // Request inputs are still the retiring instruction's; do not relaunch.
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state, captured request, load data and timeout pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      addr_r        <= {ADDR_W{1'b0}};
      wdata_r       <= {DATA_W{1'b0}};
      we_r          <= 1'b0;
      rdata_r       <= {DATA_W{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      timeout_err_r <= abort_s;
      if (launch_s) begin
        addr_r  <= {addr[ADDR_W-1:2], 2'b00};
        wdata_r <= wData;
        we_r    <= memWrite;
      end
      if (load_done_s) begin
        rdata_r <= mRData;
      end else if (abort_s && !we_r) begin
        rdata_r <= ERR_DATA;
      end
    end
  end

  assign rData      = rdata_r;
  assign timeoutErr = timeout_err_r;
  assign mAddr      = addr_r;
  assign mWData     = wdata_r;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: randomized self-checking bench. Each access is
// predicted at transaction level from the grant delay g (REQ cycles before
// grant) and read delay r (cycles after grant): busy cycles, request cycles,
// timeout and the resulting load data.
module tb_dmem_access_unit;

  localparam int T = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        memRead, memWrite;
  logic [31:0] addr, wData, rData;
  logic        stall, misalign, timeoutErr;
  logic        mReq, mWe;
  logic [31:0] mAddr, mWData;
  logic        mGnt, mRValid;
  logic [31:0] mRData;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_rdata;

  dmem_access_unit #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .TIMEOUT  (T),
    .ERR_DATA (32'hDEADBEEF)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .addr       (addr),
    .wData      (wData),
    .rData      (rData),
    .stall      (stall),
    .misalign   (misalign),
    .timeoutErr (timeoutErr),
    .mReq       (mReq),
    .mWe        (mWe),
    .mAddr      (mAddr),
    .mWData     (mWData),
    .mGnt       (mGnt),
    .mRValid    (mRValid),
    .mRData     (mRData)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One aligned access; memRead/memWrite held until the DONE cycle.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input int g, input int r,
                            input logic [31:0] rdv);
    bit is_st;
    bit exp_to;
    bit fin;
    int comp, exp_stall, exp_req;
    int cyc, stall_cnt, req_cnt, to_cnt, since;
    is_st     = wr;
    comp      = is_st ? g + 1 : g + 1 + r;
    exp_to    = (comp > T);
    exp_stall = 1 + (exp_to ? T : comp);
    exp_req   = ((g + 1) > T) ? T : g + 1;
    if (!is_st) exp_rdata = exp_to ? 32'hDEADBEEF : rdv;
    fin = 0; cyc = 0; stall_cnt = 0; req_cnt = 0; to_cnt = 0; since = -1;
    while (!fin && cyc < 64) begin
      @(negedge clock);
      memRead = rd; memWrite = wr; addr = a; wData = d;
      mGnt = 1'b0; mRValid = 1'b0; mRData = $urandom;
      #1;
      if (since >= 0) since++;
      if (mReq) begin
        if (req_cnt == g) begin
          mGnt  = 1'b1;
          since = 0;
        end
        // Read data while still requesting must be ignored.
        if ($urandom_range(0, 2) == 0) begin
          mRValid = 1'b1;
          mRData  = $urandom;
        end
        req_cnt++;
      end else if (since == r) begin
        mRValid = 1'b1;
        mRData  = rdv;
      end
      #1;
      if (cyc == 0) check("no_misalign", {31'd0, misalign}, 32'd0);
      if (mReq) begin
        check("maddr", mAddr, a);
        check("mwe", {31'd0, mWe}, {31'd0, wr});
        if (is_st) check("mwdata", mWData, d);
      end
      if (timeoutErr) to_cnt++;
      if (stall) begin
        stall_cnt++;
      end else begin
        fin = 1;
        check("done_rdata", rData, exp_rdata);
        check("done_toerr", {31'd0, timeoutErr}, {31'd0, exp_to});
      end
      cyc++;
    end
    check("bounded", {31'd0, fin}, 32'd1);
    check("stall_cycles", stall_cnt, exp_stall);
    check("req_cycles", req_cnt, exp_req);
    check("toerr_pulses", to_cnt, {31'd0, exp_to});
    @(negedge clock);
    memRead = 1'b0; memWrite = 1'b0; mGnt = 1'b0;
    mRValid = 1'b1; mRData = $urandom;  // stray response in IDLE
    #2;
    check("post_stall", {31'd0, stall}, 32'd0);
    check("post_mreq", {31'd0, mReq}, 32'd0);
    check("post_rdata", rData, exp_rdata);
    @(negedge clock);
    mRValid = 1'b0;
    #2;
    check("post2_rdata", rData, exp_rdata);
  endtask

  task automatic run_misaligned(input logic rd, input logic wr, input logic [31:0] a);
    @(negedge clock);
    memRead = rd; memWrite = wr; addr = a; wData = $urandom;
    #2;
    check("mis_pulse", {31'd0, misalign}, 32'd1);
    check("mis_stall", {31'd0, stall}, 32'd0);
    check("mis_mreq", {31'd0, mReq}, 32'd0);
    @(negedge clock);
    memRead = 1'b0; memWrite = 1'b0;
    #2;
    check("mis_clear", {31'd0, misalign}, 32'd0);
    check("mis_noreq", {31'd0, mReq}, 32'd0);
    check("mis_rdata", rData, exp_rdata);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdata"}, rData, 32'd0);
    check({tag, "_stall"}, {31'd0, stall}, 32'd0);
    check({tag, "_misalign"}, {31'd0, misalign}, 32'd0);
    check({tag, "_toerr"}, {31'd0, timeoutErr}, 32'd0);
    check({tag, "_mreq"}, {31'd0, mReq}, 32'd0);
    check({tag, "_mwe"}, {31'd0, mWe}, 32'd0);
    check({tag, "_maddr"}, mAddr, 32'd0);
    check({tag, "_mwdata"}, mWData, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=expired exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int kind;
    reset = 1'b1; memRead = 1'b0; memWrite = 1'b0; addr = 32'd0; wData = 32'd0;
    mGnt = 1'b0; mRValid = 1'b0; mRData = 32'd0;
    exp_rdata = 32'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #2;
    check_all_zero("reset");

    // Directed cases, including the timeout boundary.
    run_access(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 0, 1, 32'h0);
    run_access(1'b1, 1'b0, 32'h20, 32'h0, 3, 2, 32'h12345678);
    run_misaligned(1'b1, 1'b0, 32'h22);
    run_access(1'b1, 1'b0, 32'h30, 32'h0, 100, 1, 32'h0);
    run_access(1'b1, 1'b1, 32'h8, 32'h55AA55AA, 0, 1, 32'h0BADF00D);
    run_access(1'b0, 1'b1, 32'h44, 32'h11111111, 7, 1, 32'h0);
    run_access(1'b0, 1'b1, 32'h48, 32'h22222222, 8, 1, 32'h0);
    run_access(1'b1, 1'b0, 32'h4C, 32'h0, 5, 2, 32'hA5A5A5A5);
    run_access(1'b1, 1'b0, 32'h50, 32'h0, 5, 3, 32'h5A5A5A5A);
    run_access(1'b1, 1'b0, 32'h54, 32'h0, 7, 1, 32'h77777777);

    // Reset while a load waits for data; the late response is ignored.
    @(negedge clock);
    memRead = 1'b1; addr = 32'h40;
    @(negedge clock);
    #1;
    mGnt = 1'b1;
    @(negedge clock);
    mGnt = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; memRead = 1'b0;
    mRValid = 1'b1; mRData = 32'hFFFFFFFF;
    exp_rdata = 32'd0;
    #2;
    check_all_zero("midreset");
    @(negedge clock);
    mRValid = 1'b0;
    #2;
    check("midreset_rdata_hold", rData, 32'd0);
    check("midreset_idle", {31'd0, mReq}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 4);
      a = $urandom & 32'hFFFFFFFC;
      case (kind)
        0, 4: run_access(1'b1, 1'b0, a, $urandom, $urandom_range(0, 9), $urandom_range(1, 3), $urandom);
        1: run_access(1'b0, 1'b1, a, $urandom, $urandom_range(0, 9), $urandom_range(1, 3), $urandom);
        2: run_access(1'b1, 1'b1, a, $urandom, $urandom_range(0, 9), $urandom_range(1, 3), $urandom);
        default: run_misaligned(1'($urandom_range(0, 1)), 1'b1, a | $urandom_range(1, 3));
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Load/store stage directly downstream of the single-cycle datapath.
- Consumes the datapath's ALUOut (address) and WriteData, plus the control unit's memRead/memWrite.
- Runs a req/gnt/rvalid handshake to a data memory that may insert wait states, and returns ReadData to the datapath.
- Asserts stall so the PC and register file hold until the access completes; flags misaligned and timed-out accesses.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT before the access is aborted; legal range 1..1023, counter width 10 bits.
- ERR_DATA, 32'hDEADBEEF, value returned on rData when a read times out.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- memRead  in  1  load request from control unit.
- memWrite  in  1  store request from control unit.
- addr  in  ADDR_W  byte address (datapath ALUOut).
- wData  in  DATA_W  store data (datapath WriteData).
- rData  out  DATA_W  load data to datapath (ReadData).
- stall  out  1  hold PC/regfile write while high.
- misalign  out  1  one-cycle pulse: access with addr[1:0]!=0.
- timeoutErr  out  1  one-cycle pulse: access aborted after TIMEOUT.
- mReq  out  1  memory request.
- mWe  out  1  1 = write, 0 = read; valid while mReq.
- mAddr  out  ADDR_W  word-aligned memory address; valid while mReq.
- mWData  out  DATA_W  write data; valid while mReq.
- mGnt  in  1  memory accepted request this cycle.
- mRValid  in  1  read data valid this cycle.
- mRData  in  DATA_W  read data.

Behaviour:
- Reset (synchronous, active-high, one clock on the clock port) gives:
  - state = IDLE;
  - rData, mAddr, mWData = 0;
  - mReq, mWe, stall, misalign, timeoutErr = 0;
  - timeout counter = 0.
- Reset mid-operation abandons the access. mReq is low from the next cycle, and a late mGnt/mRValid is ignored in IDLE.
- Access valid = memRead | memWrite. memWrite has priority when both are high (treated as a store).
- FSM has 4 states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Valid and addr[1:0]==0: capture addr, wData and we into registers, go to REQ. stall is driven combinationally high in this same cycle.
  - Valid and addr[1:0]!=0: misalign=1 for this cycle, no memory access, stall=0, stay in IDLE.
  - Not valid: stall=0.
- REQ:
  - mReq=1. mWe/mAddr/mWData come from the captured registers and are held stable until grant.
  - mGnt=1 with store: go to DONE.
  - mGnt=1 with load: go to WAIT. An mRValid in the grant cycle is ignored; data is earliest the cycle after grant.
- WAIT:
  - mReq=0.
  - On mRValid: register mRData into rData, go to DONE.
- stall=1 throughout REQ and WAIT.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT without completion: timeoutErr=1 for one cycle, mReq drops, and the FSM goes to DONE.
  - If the timed-out access was a load, rData=ERR_DATA.
  - Completion in the same cycle the count reaches TIMEOUT counts as success; no error is raised.
- DONE:
  - Lasts exactly 1 cycle with stall=0, so the processor retires the instruction.
  - The memRead/memWrite still presented this cycle are ignored (no relaunch).
  - Next state is IDLE.
- rData holds its last value between loads; a store never changes it.
- Latency:
  - Zero-wait store: 3 cycles of instruction occupancy (IDLE-detect, REQ, DONE).
  - Load with gnt in REQ and rvalid 1 cycle later: 4 cycles.
- mAddr[1:0] is always 0.

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, DONE=2'd3);
  - ERR_DATA default;
  - TIMEOUT counter width (10).
- One natural sub-module: wait_counter. It is a clear/enable/terminal-count counter parameterised by TIMEOUT, driving the timeout signal.

Test Plan:
- Zero-wait store: memWrite=1, addr=0x10, wData=0xCAFEF00D, mGnt tied 1 → mReq/mWe high one cycle with mAddr=0x10 and mWData=0xCAFEF00D. stall high for 2 cycles then low for the DONE cycle; rData unchanged.
- Load with waits: memRead=1, addr=0x20, mGnt after 3 cycles, mRValid 2 cycles later with 0x12345678 → stall high through REQ/WAIT, rData=0x12345678 in DONE, then IDLE.
- Misaligned: memRead=1, addr=0x22 → misalign pulse 1 cycle, mReq never asserted, stall=0.
- Timeout: TIMEOUT=8, memRead=1, mGnt never asserted → timeoutErr pulses on the 8th cycle after REQ entry, rData=0xDEADBEEF, FSM returns to IDLE via DONE.
- Reset mid-read: load in WAIT, reset=1 one cycle, then mRValid=1 with 0xFFFFFFFF → all outputs zero after reset and rData stays 0.
- Simultaneous memRead=memWrite=1, addr=0x8 → treated as a store (mWe=1); rData unchanged.
